// File: rtl/pcap_framing_pkg.sv
// Shared definitions for the PCAP framing block: widths, FSM states and error codes.
package pcap_framing_pkg;

    localparam int TS_W   = 48;
    localparam int FLEN_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        ENABLED = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_DOUBLE   = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;

endpackage

// File: rtl/pcap_edge_detect.sv
// Single-bit rising-edge detector: input high while its one-cycle-delayed copy is low.
module pcap_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_dly;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_dly <= 1'b0;
        end else begin
            din_dly <= din;
        end
    end

    assign rise = din & ~din_dly;

endmodule

// File: rtl/pcap_framing.sv
// PCAP acquisition framing: arms on a pulse, timestamps captures directly or per frame,
// and reports the frame length alongside each capture strobe.
module pcap_framing
    import pcap_framing_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              arm_i,
    input  logic              disarm_i,
    input  logic              enable_i,
    input  logic              frame_i,
    input  logic              capture_i,
    input  logic              framed_mode_i,
    output logic              active_o,
    output logic              capture_o,
    output logic [TS_W-1:0]   capture_ts_o,
    output logic [FLEN_W-1:0] frame_length_o,
    output logic [1:0]        err_o
);

    state_t            state;
    logic [TS_W-1:0]   ts_count;
    logic [TS_W-1:0]   frame_start;
    logic [FLEN_W-1:0] frame_ticks;
    logic              framed;
    logic              frame_open;
    logic              pending;
    logic              arm_rise;
    logic              frame_rise;
    logic              capture_rise;

    pcap_edge_detect u_arm_edge     (.clk(clk_i), .rst(reset_i), .din(arm_i),     .rise(arm_rise));
    pcap_edge_detect u_frame_edge   (.clk(clk_i), .rst(reset_i), .din(frame_i),   .rise(frame_rise));
    pcap_edge_detect u_capture_edge (.clk(clk_i), .rst(reset_i), .din(capture_i), .rise(capture_rise));

    // Frame ticks count cycles after the opening edge, so the closing edge adds one.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state          <= IDLE;
            active_o       <= 1'b0;
            capture_o      <= 1'b0;
            capture_ts_o   <= '0;
            frame_length_o <= '0;
            err_o          <= ERR_NONE;
            ts_count       <= '0;
            frame_start    <= '0;
            frame_ticks    <= '0;
            framed         <= 1'b0;
            frame_open     <= 1'b0;
            pending        <= 1'b0;
        end else begin
            capture_o <= 1'b0;
            if (disarm_i) begin
                state      <= IDLE;
                active_o   <= 1'b0;
                pending    <= 1'b0;
                frame_open <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm_rise) begin
                            state       <= ARMED;
                            active_o    <= 1'b1;
                            ts_count    <= '0;
                            err_o       <= ERR_NONE;
                            framed      <= framed_mode_i;
                            pending     <= 1'b0;
                            frame_open  <= 1'b0;
                            frame_ticks <= '0;
                        end
                    end
                    ARMED: begin
                        if (enable_i) begin
                            state    <= ENABLED;
                            ts_count <= ts_count + TS_W'(1);
                        end
                    end
                    ENABLED: begin
                        if (!enable_i) begin
                            state      <= IDLE;
                            active_o   <= 1'b0;
                            pending    <= 1'b0;
                            frame_open <= 1'b0;
                        end else begin
                            ts_count <= ts_count + TS_W'(1);
                            if (!framed) begin
                                if (capture_rise) begin
                                    capture_o      <= 1'b1;
                                    capture_ts_o   <= ts_count;
                                    frame_length_o <= '0;
                                end
                            end else if (frame_rise) begin
                                if (pending) begin
                                    capture_o      <= 1'b1;
                                    capture_ts_o   <= frame_start;
                                    frame_length_o <= frame_ticks + FLEN_W'(1);
                                end
                                frame_start <= ts_count;
                                frame_ticks <= '0;
                                frame_open  <= 1'b1;
                                pending     <= capture_rise;
                            end else if (frame_open) begin
                                if (capture_rise && pending) begin
                                    err_o      <= ERR_DOUBLE;
                                    state      <= IDLE;
                                    active_o   <= 1'b0;
                                    pending    <= 1'b0;
                                    frame_open <= 1'b0;
                                end else if (frame_ticks == '1) begin
                                    err_o      <= ERR_OVERFLOW;
                                    state      <= IDLE;
                                    active_o   <= 1'b0;
                                    pending    <= 1'b0;
                                    frame_open <= 1'b0;
                                end else begin
                                    frame_ticks <= frame_ticks + FLEN_W'(1);
                                    if (capture_rise) begin
                                        pending <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pcap_framing.sv
// Self-checking bench for pcap_framing: a directed vector table followed by
// hand-written multi-cycle sequences for the framing corner cases.
module tb_pcap_framing;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        arm_i;
    logic        disarm_i;
    logic        enable_i;
    logic        frame_i;
    logic        capture_i;
    logic        framed_mode_i;
    logic        active_o;
    logic        capture_o;
    logic [47:0] capture_ts_o;
    logic [31:0] frame_length_o;
    logic [1:0]  err_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int strobes  = 0;

    pcap_framing dut (
        .clk_i(clk_i), .reset_i(reset_i), .arm_i(arm_i), .disarm_i(disarm_i),
        .enable_i(enable_i), .frame_i(frame_i), .capture_i(capture_i),
        .framed_mode_i(framed_mode_i), .active_o(active_o), .capture_o(capture_o),
        .capture_ts_o(capture_ts_o), .frame_length_o(frame_length_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (capture_o === 1'b1) strobes++;
    end

    typedef struct {
        logic        arm, disarm, enable, frame, capture, mode;
        logic        active, cap;
        logic [47:0] ts;
        logic [31:0] fl;
        logic [1:0]  err;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(input logic a, d, e, f, c, m, x_act, x_cap,
                                input logic [47:0] x_ts, input logic [31:0] x_fl,
                                input logic [1:0] x_err);
        vec_t v;
        v.arm = a; v.disarm = d; v.enable = e; v.frame = f; v.capture = c; v.mode = m;
        v.active = x_act; v.cap = x_cap; v.ts = x_ts; v.fl = x_fl; v.err = x_err;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        arm_i = 0; disarm_i = 0; enable_i = 0; frame_i = 0; capture_i = 0; framed_mode_i = 0;
        reset_i = 1;
        tick();
        reset_i = 0;
        tick();
    endtask

    task automatic apply_stimulus(input vec_t v);
        arm_i = v.arm; disarm_i = v.disarm; enable_i = v.enable;
        frame_i = v.frame; capture_i = v.capture; framed_mode_i = v.mode;
        tick();
    endtask

    // After this, the cycle being driven has timestamp counter value cyc.
    task automatic arm_and_enable(input logic mode);
        enable_i = 0;
        arm_i = 1;
        framed_mode_i = mode;
        tick();
        arm_i = 0;
        enable_i = 1;
        cyc = 0;
    endtask

    task automatic pulse_at(input int c, input logic f, input logic cap);
        while (cyc < c) tick();
        frame_i = f;
        capture_i = cap;
        tick();
        frame_i = 0;
        capture_i = 0;
    endtask

    initial begin
        //               arm dis en fr cap md  act cap ts  fl err
        vecs[0]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0);
        vecs[5]  = mk(0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0);
        vecs[6]  = mk(0, 0, 1, 0, 1, 0,  1, 1, 2, 0, 0);
        vecs[7]  = mk(0, 0, 1, 0, 1, 0,  1, 0, 2, 0, 0);
        vecs[8]  = mk(1, 0, 1, 0, 0, 0,  1, 0, 2, 0, 0);
        vecs[9]  = mk(0, 0, 1, 0, 1, 0,  1, 1, 5, 0, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0,  0, 0, 5, 0, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 0,  0, 0, 5, 0, 0);
        vecs[12] = mk(1, 0, 0, 0, 0, 1,  1, 0, 5, 0, 0);
        vecs[13] = mk(0, 0, 1, 0, 0, 0,  1, 0, 5, 0, 0);
        vecs[14] = mk(0, 0, 1, 0, 1, 0,  1, 0, 5, 0, 0);
        vecs[15] = mk(0, 0, 1, 1, 0, 0,  1, 0, 5, 0, 0);
        vecs[16] = mk(0, 0, 1, 0, 1, 0,  1, 0, 5, 0, 0);
        vecs[17] = mk(0, 0, 1, 0, 0, 0,  1, 0, 5, 0, 0);
        vecs[18] = mk(0, 0, 1, 1, 0, 0,  1, 1, 2, 3, 0);
        vecs[19] = mk(0, 0, 1, 0, 0, 0,  1, 0, 2, 3, 0);
        vecs[20] = mk(0, 0, 1, 1, 0, 0,  1, 0, 2, 3, 0);
        vecs[21] = mk(0, 0, 1, 0, 1, 0,  1, 0, 2, 3, 0);
        vecs[22] = mk(0, 0, 1, 0, 0, 0,  1, 0, 2, 3, 0);
        vecs[23] = mk(0, 0, 1, 0, 1, 0,  0, 0, 2, 3, 1);
        vecs[24] = mk(0, 0, 0, 0, 0, 0,  0, 0, 2, 3, 1);
        vecs[25] = mk(1, 0, 0, 0, 0, 0,  1, 0, 2, 3, 0);
        vecs[26] = mk(0, 1, 0, 0, 0, 0,  0, 0, 2, 3, 0);

        apply_reset();
        check_output("reset_active", active_o, 0);
        check_output("reset_capture", capture_o, 0);
        check_output("reset_ts", capture_ts_o, 0);
        check_output("reset_flen", frame_length_o, 0);
        check_output("reset_err", err_o, 0);

        for (int i = 0; i < 27; i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d_active", i), active_o, vecs[i].active);
            check_output($sformatf("vec%0d_capture", i), capture_o, vecs[i].cap);
            check_output($sformatf("vec%0d_ts", i), capture_ts_o, vecs[i].ts);
            check_output($sformatf("vec%0d_flen", i), frame_length_o, vecs[i].fl);
            check_output($sformatf("vec%0d_err", i), err_o, vecs[i].err);
        end

        $display("[TB] direct capture 10 cycles after enable");
        apply_reset();
        arm_and_enable(0);
        strobes = 0;
        pulse_at(10, 0, 1);
        check_output("direct_strobe", capture_o, 1);
        check_output("direct_ts", capture_ts_o, 10);
        check_output("direct_flen", frame_length_o, 0);
        tick();
        check_output("direct_strobe_low", capture_o, 0);
        check_output("direct_strobe_count", strobes, 1);

        $display("[TB] framed capture, frames 5-105 and 105-205");
        apply_reset();
        arm_and_enable(1);
        strobes = 0;
        pulse_at(5, 1, 0);
        pulse_at(50, 0, 1);
        check_output("framed_no_early_strobe", capture_o, 0);
        pulse_at(105, 1, 0);
        check_output("framed_strobe", capture_o, 1);
        check_output("framed_ts", capture_ts_o, 5);
        check_output("framed_flen", frame_length_o, 100);
        pulse_at(205, 1, 0);
        check_output("framed_empty_frame", capture_o, 0);
        tick();
        check_output("framed_strobe_count", strobes, 1);
        check_output("framed_active", active_o, 1);

        $display("[TB] simultaneous frame and capture edge");
        apply_reset();
        arm_and_enable(1);
        strobes = 0;
        pulse_at(5, 1, 0);
        pulse_at(50, 0, 1);
        pulse_at(105, 1, 1);
        check_output("simul_strobe", capture_o, 1);
        check_output("simul_ts", capture_ts_o, 5);
        check_output("simul_flen", frame_length_o, 100);
        pulse_at(205, 1, 0);
        check_output("simul_next_strobe", capture_o, 1);
        check_output("simul_next_ts", capture_ts_o, 105);
        check_output("simul_next_flen", frame_length_o, 100);
        tick();
        check_output("simul_strobe_count", strobes, 2);

        $display("[TB] double capture within one frame");
        apply_reset();
        arm_and_enable(1);
        strobes = 0;
        pulse_at(5, 1, 0);
        pulse_at(20, 0, 1);
        pulse_at(30, 0, 1);
        check_output("double_err", err_o, 1);
        check_output("double_active", active_o, 0);
        pulse_at(105, 1, 0);
        check_output("double_no_strobe", capture_o, 0);
        tick();
        check_output("double_strobe_count", strobes, 0);

        $display("[TB] disarm with capture pending");
        apply_reset();
        arm_and_enable(1);
        strobes = 0;
        pulse_at(5, 1, 0);
        pulse_at(50, 0, 1);
        while (cyc < 60) tick();
        disarm_i = 1;
        tick();
        disarm_i = 0;
        check_output("disarm_active", active_o, 0);
        pulse_at(105, 1, 0);
        tick();
        check_output("disarm_strobe_count", strobes, 0);
        check_output("disarm_err", err_o, 0);

        $display("[TB] reset with capture pending, then re-arm");
        apply_reset();
        arm_and_enable(0);
        pulse_at(7, 0, 1);
        enable_i = 0;
        tick();
        arm_and_enable(1);
        strobes = 0;
        pulse_at(5, 1, 0);
        pulse_at(50, 0, 1);
        while (cyc < 60) tick();
        reset_i = 1;
        tick();
        check_output("rst_active", active_o, 0);
        check_output("rst_capture", capture_o, 0);
        check_output("rst_ts", capture_ts_o, 0);
        check_output("rst_flen", frame_length_o, 0);
        check_output("rst_err", err_o, 0);
        reset_i = 0;
        enable_i = 0;
        tick();
        frame_i = 1;
        tick();
        frame_i = 0;
        check_output("rst_strobe_count", strobes, 0);
        arm_and_enable(0);
        pulse_at(3, 0, 1);
        check_output("rearm_strobe", capture_o, 1);
        check_output("rearm_ts", capture_ts_o, 3);
        check_output("rearm_active", active_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
